// File: rtl/deser_pkg.sv
// Shared types and helpers for the bit deserializer: output-register state
// and the bit counter width.
package deser_pkg;

    typedef enum logic {
        StEmpty,
        StFull
    } out_state_e;

    // Wide enough to hold every value from 0 to width.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/deser_shift_reg.sv
// Serial shift register and bit counter. Raises complete on the edge that
// accepts the WIDTH-th bit and exposes the full word combinationally.
module deser_shift_reg
    import deser_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             bit_i,
    input  logic                             bit_valid_i,
    input  logic                             clear_i,
    output logic [WIDTH-1:0]                 word_o,
    output logic                             complete_o,
    output logic [cnt_width(WIDTH)-1:0]      bit_count_o
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             accept;

    assign accept = bit_valid_i & ~clear_i;

    // The shifted value already contains the incoming bit, so it doubles as
    // the completed word without waiting a cycle.
    always_comb begin
        if (MSB_FIRST) begin
            word_o = {shreg_q[WIDTH-2:0], bit_i};
        end else begin
            word_o = {bit_i, shreg_q[WIDTH-1:1]};
        end
    end

    assign complete_o = accept && (count_q == CntW'(WIDTH - 1));

    always_comb begin
        shreg_d = shreg_q;
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (accept) begin
            shreg_d = word_o;
            count_d = complete_o ? '0 : count_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            count_q <= '0;
        end else begin
            shreg_q <= shreg_d;
            count_q <= count_d;
        end
    end

    assign bit_count_o = count_q;

endmodule

// File: rtl/bit_deserializer.sv
// Packs a serial bit stream into WIDTH-bit words behind a one-entry
// valid/ready output register; flags words dropped under backpressure.
module bit_deserializer
    import deser_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         bit_in,
    input  logic                         bit_valid,
    input  logic                         clear,
    output logic [WIDTH-1:0]             word_out,
    output logic                         word_valid,
    input  logic                         word_ready,
    output logic [cnt_width(WIDTH)-1:0]  bit_count,
    output logic                         overflow
);

    out_state_e       state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] new_word;
    logic             complete;

    deser_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk         (clk),
        .rst         (rst),
        .bit_i       (bit_in),
        .bit_valid_i (bit_valid),
        .clear_i     (clear),
        .word_o      (new_word),
        .complete_o  (complete),
        .bit_count_o (bit_count)
    );

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        overflow_d = 1'b0;
        unique case (state_q)
            StEmpty: begin
                if (complete) begin
                    word_d  = new_word;
                    state_d = StFull;
                end
            end
            StFull: begin
                if (complete && word_ready) begin
                    word_d = new_word;
                end else if (complete) begin
                    overflow_d = 1'b1;
                end else if (word_ready) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StEmpty;
            word_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            overflow_q <= overflow_d;
        end
    end

    assign word_out   = word_q;
    assign word_valid = (state_q == StFull);
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_bit_deserializer.sv
// Bench for bit_deserializer: MSB-first and LSB-first instances share one
// stimulus stream and are compared each cycle against a queue-based model.
module tb_bit_deserializer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CntW  = $clog2(WIDTH + 1);

    logic             clk;
    logic             rst;
    logic             bit_in;
    logic             bit_valid;
    logic             clear;
    logic             word_ready;
    logic [WIDTH-1:0] out_m, out_l;
    logic             valid_m, valid_l;
    logic [CntW-1:0]  cnt_m, cnt_l;
    logic             ovf_m, ovf_l;

    int n_checks = 0;
    int n_fail   = 0;

    bit_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .clear      (clear),
        .word_out   (out_m),
        .word_valid (valid_m),
        .word_ready (word_ready),
        .bit_count  (cnt_m),
        .overflow   (ovf_m)
    );

    bit_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .clear      (clear),
        .word_out   (out_l),
        .word_valid (valid_l),
        .word_ready (word_ready),
        .bit_count  (cnt_l),
        .overflow   (ovf_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: received bits in arrival order; a word is the first WIDTH of them.
    bit               mq[$];
    logic [WIDTH-1:0] m_msb, m_lsb;
    bit               m_valid, m_ovf;

    always @(posedge clk or posedge rst) begin
        bit               done;
        logic [WIDTH-1:0] wm, wl;
        if (rst) begin
            mq.delete();
            m_msb   = '0;
            m_lsb   = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            done  = 1'b0;
            wm    = '0;
            wl    = '0;
            m_ovf = 1'b0;
            if (clear) begin
                mq.delete();
            end else if (bit_valid) begin
                mq.push_back(bit_in);
                if (mq.size() == WIDTH) begin
                    done = 1'b1;
                    for (int i = 0; i < WIDTH; i++) begin
                        wm[WIDTH-1-i] = mq[i];
                        wl[i]         = mq[i];
                    end
                    mq.delete();
                end
            end
            if (done) begin
                if (!m_valid || word_ready) begin
                    m_msb   = wm;
                    m_lsb   = wl;
                    m_valid = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (m_valid && word_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("msb_valid", 32'(valid_m), 32'(m_valid));
        chk("lsb_valid", 32'(valid_l), 32'(m_valid));
        chk("msb_ovf",   32'(ovf_m),   32'(m_ovf));
        chk("lsb_ovf",   32'(ovf_l),   32'(m_ovf));
        chk("msb_count", 32'(cnt_m),   32'(mq.size()));
        chk("lsb_count", 32'(cnt_l),   32'(mq.size()));
        chk("msb_word",  32'(out_m),   32'(m_msb));
        chk("lsb_word",  32'(out_l),   32'(m_lsb));
    end

    task automatic cyc(input logic bv, input logic b, input logic clr, input logic rdy);
        @(negedge clk);
        bit_valid  = bv;
        bit_in     = b;
        clear      = clr;
        word_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Sends w[7] first; word_ready is rdy_last only on the final bit.
    task automatic send8(input logic [7:0] w, input logic rdy_rest, input logic rdy_last,
                         input int max_gap);
        for (int i = 7; i >= 0; i--) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int g = 0; g < gap; g++) cyc(1'b0, 1'($urandom), 1'b0, rdy_rest);
            cyc(1'b1, w[i], 1'b0, (i == 0) ? rdy_last : rdy_rest);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        bit_in     = 1'b0;
        bit_valid  = 1'b0;
        clear      = 1'b0;
        word_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_valid", 32'(valid_m), 32'd0);
        chk("reset_word",  32'(out_m),   32'd0);
        chk("reset_count", 32'(cnt_m),   32'd0);
        rst = 1'b0;

        // Basic word, both bit orders.
        send8(8'hC0, 1'b1, 1'b1, 0);
        chk("t1_valid", 32'(valid_m), 32'd1);
        chk("t1_msb",   32'(out_m),   32'hC0);
        chk("t1_lsb",   32'(out_l),   32'h03);
        chk("t1_count", 32'(cnt_m),   32'd0);
        chk("t1_model", 32'(m_msb),   32'hC0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1_drain", 32'(valid_m), 32'd0);

        // Backpressure: second word dropped.
        send8(8'hC0, 1'b0, 1'b0, 0);
        send8(8'hFF, 1'b0, 1'b0, 0);
        chk("ovf_pulse", 32'(ovf_m),   32'd1);
        chk("ovf_msb",   32'(out_m),   32'hC0);
        chk("ovf_lsb",   32'(out_l),   32'h03);
        chk("ovf_valid", 32'(valid_m), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovf_end",   32'(ovf_m),   32'd0);

        // Handshake on the completing edge.
        send8(8'h5A, 1'b0, 1'b1, 0);
        chk("sim_ovf",   32'(ovf_m),   32'd0);
        chk("sim_msb",   32'(out_m),   32'h5A);
        chk("sim_valid", 32'(valid_m), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Clear aborts a partial word; bit on the clear edge is ignored.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("clr_count", 32'(cnt_m), 32'd0);
        send8(8'h0F, 1'b1, 1'b1, 0);
        chk("clr_msb", 32'(out_m), 32'h0F);
        chk("clr_lsb", 32'(out_l), 32'hF0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        send8(8'h0F, 1'b1, 1'b1, 3);
        chk("gap_msb", 32'(out_m), 32'h0F);
        chk("gap_lsb", 32'(out_l), 32'hF0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-word while FULL.
        send8(8'hA5, 1'b0, 1'b0, 0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        bit_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(valid_m), 32'd0);
        chk("arst_word",  32'(out_m),   32'd0);
        chk("arst_count", 32'(cnt_m),   32'd0);
        chk("arst_ovf",   32'(ovf_m),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        send8(8'h3C, 1'b1, 1'b1, 0);
        chk("arst_msb", 32'(out_m), 32'h3C);
        chk("arst_lsb", 32'(out_l), 32'h3C);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            cyc(1'($urandom_range(3, 0) != 0), 1'($urandom),
                1'($urandom_range(15, 0) == 0), 1'($urandom_range(2, 0) == 0));
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
